// File: rtl/frame_uart_sender.sv
// Dumps one WIDTH x HEIGHT frame from a BRAM read port to a byte UART: sync header, pixels, 8-bit sum.
// One byte in flight at a time; each start waits for uart_done_i, and each pixel costs 1 + READ_LATENCY cycles before its send.
module frame_uart_sender #(
    parameter int          WIDTH        = 64,
    parameter int          HEIGHT       = 64,
    parameter int          BIT_DEPTH    = 8,
    parameter int          READ_LATENCY = 2,
    parameter logic [7:0]  SYNC0        = 8'hA5,
    parameter logic [7:0]  SYNC1        = 8'h5A,
    localparam int         NPIX         = WIDTH * HEIGHT,
    localparam int         AW           = (NPIX > 1) ? $clog2(NPIX) : 1
) (
    input  logic                 clk,
    input  logic                 sys_rst_n,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [AW-1:0]        addr_o,
    output logic                 addr_valid_o,
    input  logic [BIT_DEPTH-1:0] pixel_i,
    output logic [7:0]           uart_data_o,
    output logic                 uart_start_o,
    input  logic                 uart_done_i
);

    localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY + 1) : 1;

    typedef enum logic [3:0] {
        IDLE, HDR0, HDR0_W, HDR1, HDR1_W, FETCH, LAT, SEND, SEND_W, CSUM, CSUM_W
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [7:0]    csum_q, csum_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [7:0]    data_q, data_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [7:0]    pix_ext;

    always_comb begin
        pix_ext = '0;
        pix_ext[BIT_DEPTH-1:0] = pixel_i;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        csum_d  = csum_q;
        lat_d   = lat_q;
        data_d  = data_q;
        done_d  = 1'b0;
        // busy stays up through the done cycle and rises again there on a back-to-back start
        busy_d  = (state_q != IDLE) || start_i;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = HDR0;
                    cnt_d   = '0;
                    csum_d  = '0;
                    data_d  = SYNC0;
                end
            end
            HDR0:   state_d = HDR0_W;
            HDR0_W: begin
                if (uart_done_i) begin
                    state_d = HDR1;
                    data_d  = SYNC1;
                end
            end
            HDR1:   state_d = HDR1_W;
            HDR1_W: if (uart_done_i) state_d = FETCH;
            FETCH: begin
                state_d = LAT;
                lat_d   = '0;
            end
            LAT: begin
                if (lat_q == LW'(READ_LATENCY - 1)) begin
                    data_d  = pix_ext;
                    state_d = SEND;
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            SEND: begin
                csum_d  = csum_q + data_q;
                state_d = SEND_W;
            end
            SEND_W: begin
                if (uart_done_i) begin
                    if (cnt_q == AW'(NPIX - 1)) begin
                        state_d = CSUM;
                        data_d  = csum_q;
                    end else begin
                        cnt_d   = cnt_q + AW'(1);
                        state_d = FETCH;
                    end
                end
            end
            CSUM:   state_d = CSUM_W;
            CSUM_W: begin
                if (uart_done_i) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            csum_q  <= '0;
            lat_q   <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
            lat_q   <= lat_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign addr_o       = cnt_q;
    assign addr_valid_o = (state_q == FETCH);
    assign uart_data_o  = data_q;
    assign uart_start_o = (state_q == HDR0) || (state_q == HDR1) ||
                          (state_q == SEND) || (state_q == CSUM);

endmodule

// File: tb/tb_frame_uart_sender.sv
// Bench for frame_uart_sender: 4x2 frames on an 8-bit and a 4-bit instance, BRAM and uart_tx models, byte scoreboard.
module tb_frame_uart_sender;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       sys_rst_n;
    logic       start_a, start_b;
    logic       busy_a, done_a, av_a, us_a, ud_a;
    logic       busy_b, done_b, av_b, us_b, ud_b;
    logic [2:0] addr_a, addr_b;
    logic [7:0] pix_a, data_a, data_b;
    logic [3:0] pix_b;
    logic       mdone_a = 1'b0, mdone_b = 1'b0, inj_a, inj_f_a = 1'b0, inj_fetch;

    assign ud_a = mdone_a | inj_a | inj_f_a;
    assign ud_b = mdone_b;

    frame_uart_sender #(.WIDTH(4), .HEIGHT(2), .BIT_DEPTH(8), .READ_LATENCY(2)) dut_a (
        .clk(clk), .sys_rst_n(sys_rst_n), .start_i(start_a), .busy_o(busy_a), .done_o(done_a),
        .addr_o(addr_a), .addr_valid_o(av_a), .pixel_i(pix_a), .uart_data_o(data_a),
        .uart_start_o(us_a), .uart_done_i(ud_a));

    frame_uart_sender #(.WIDTH(4), .HEIGHT(2), .BIT_DEPTH(4), .READ_LATENCY(2)) dut_b (
        .clk(clk), .sys_rst_n(sys_rst_n), .start_i(start_b), .busy_o(busy_b), .done_o(done_b),
        .addr_o(addr_b), .addr_valid_o(av_b), .pixel_i(pix_b), .uart_data_o(data_b),
        .uart_start_o(us_b), .uart_done_i(ud_b));

    // BRAM with output register; non-read cycles load a poison value so early capture shows up
    logic [7:0] mem_a [8];
    logic [3:0] mem_b [8];
    logic [7:0] s1_a, s2_a;
    logic [3:0] s1_b, s2_b;
    always @(posedge clk) begin
        s1_a <= av_a ? mem_a[addr_a] : 8'hEE;
        s2_a <= s1_a;
        s1_b <= av_b ? mem_b[addr_b] : 4'hC;
        s2_b <= s1_b;
    end
    assign pix_a = s2_a;
    assign pix_b = s2_b;

    int n_tests = 0, n_fail = 0;
    logic [7:0] exp_a[$], exp_b[$];
    int         exp_addr_a[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // uart_tx models: done pulse 10 cycles after each start, byte must hold meanwhile
    int         pend_a = 0, pend_b = 0, done_cnt_a = 0, done_cnt_b = 0;
    logic [7:0] lat_a, lat_b;
    always @(negedge clk) begin
        if (!sys_rst_n) begin
            pend_a = 0; mdone_a = 1'b0; inj_f_a = 1'b0;
        end else begin
            if (done_a) done_cnt_a++;
            inj_f_a = inj_fetch && av_a;
            if (av_a) begin
                chk("addr_pending", 32'(exp_addr_a.size() > 0), 1);
                if (exp_addr_a.size() > 0) chk("addr", 32'(addr_a), exp_addr_a.pop_front());
            end
            if (us_a) begin
                chk("a_start_overlap", pend_a, 0);
                chk("a_busy_at_start", 32'(busy_a), 1);
                chk("a_byte_pending", 32'(exp_a.size() > 0), 1);
                if (exp_a.size() > 0) chk("a_byte", 32'(data_a), 32'(exp_a.pop_front()));
                lat_a = data_a; pend_a = 10; mdone_a = 1'b0;
            end else if (pend_a > 0) begin
                chk("a_data_stable", 32'(data_a), 32'(lat_a));
                pend_a--; mdone_a = (pend_a == 0);
            end else begin
                mdone_a = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!sys_rst_n) begin
            pend_b = 0; mdone_b = 1'b0;
        end else begin
            if (done_b) done_cnt_b++;
            if (us_b) begin
                chk("b_start_overlap", pend_b, 0);
                chk("b_busy_at_start", 32'(busy_b), 1);
                chk("b_byte_pending", 32'(exp_b.size() > 0), 1);
                if (exp_b.size() > 0) chk("b_byte", 32'(data_b), 32'(exp_b.pop_front()));
                lat_b = data_b; pend_b = 10; mdone_b = 1'b0;
            end else if (pend_b > 0) begin
                chk("b_data_stable", 32'(data_b), 32'(lat_b));
                pend_b--; mdone_b = (pend_b == 0);
            end else begin
                mdone_b = 1'b0;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_frame_a();
        logic [7:0] s = 8'h00;
        exp_a.push_back(8'hA5);
        exp_a.push_back(8'h5A);
        for (int i = 0; i < 8; i++) begin
            exp_a.push_back(mem_a[i]);
            exp_addr_a.push_back(i);
            s = s + mem_a[i];
        end
        exp_a.push_back(s);
    endtask

    task automatic push_frame_b();
        logic [7:0] s = 8'h00;
        exp_b.push_back(8'hA5);
        exp_b.push_back(8'h5A);
        for (int i = 0; i < 8; i++) begin
            exp_b.push_back({4'h0, mem_b[i]});
            s = s + {4'h0, mem_b[i]};
        end
        exp_b.push_back(s);
    endtask

    task automatic pulse_a();
        start_a = 1'b1; cyc(1); start_a = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            seen = sel ? done_b : done_a;
        end
        chk(tag, 32'(seen), 1);
    endtask

    task automatic run_a(input string tag);
        int base;
        base = done_cnt_a;
        push_frame_a();
        pulse_a();
        wait_done(1'b0, tag);
        cyc(30);
        chk({tag, "_done_cnt"}, done_cnt_a - base, 1);
        chk({tag, "_bytes_left"}, exp_a.size(), 0);
        chk({tag, "_addr_left"}, exp_addr_a.size(), 0);
        chk({tag, "_busy_after"}, 32'(busy_a), 0);
    endtask

    initial begin
        int  base;
        bit  seen;
        sys_rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; inj_a = 1'b0; inj_fetch = 1'b0;
        for (int i = 0; i < 8; i++) mem_a[i] = 8'(8'h10 + i);
        mem_b = '{4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA};
        cyc(3);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_addr", 32'(addr_a), 0);
        chk("rst_addr_valid", 32'(av_a), 0);
        chk("rst_data", 32'(data_a), 0);
        chk("rst_uart_start", 32'(us_a), 0);
        sys_rst_n = 1'b1;
        cyc(2);

        // spurious uart_done_i in IDLE
        inj_a = 1'b1; cyc(1); inj_a = 1'b0;
        cyc(5);
        chk("idle_spurious_busy", 32'(busy_a), 0);

        // frame 0x10..0x17 with a spurious done in every FETCH
        inj_fetch = 1'b1;
        run_a("t1");
        inj_fetch = 1'b0;

        // all 0xFF: checksum wraps to 0xF8
        for (int i = 0; i < 8; i++) mem_a[i] = 8'hFF;
        run_a("t2");

        // start_i chattering during the frame
        for (int i = 0; i < 8; i++) mem_a[i] = 8'(8'h10 + i);
        base = done_cnt_a;
        push_frame_a();
        for (int k = 0; k < 8; k++) begin
            start_a = 1'b1; cyc(1); start_a = 1'b0; cyc(6);
        end
        wait_done(1'b0, "t4a");
        cyc(40);
        chk("t4a_done_cnt", done_cnt_a - base, 1);
        chk("t4a_bytes_left", exp_a.size(), 0);

        // start_i held: second frame starts the cycle after done_o
        base = done_cnt_a;
        push_frame_a();
        push_frame_a();
        start_a = 1'b1;
        wait_done(1'b0, "t4b_first");
        cyc(1);
        chk("t4b_b2b_start", 32'(us_a), 1);
        chk("t4b_b2b_data", 32'(data_a), 32'h A5);
        start_a = 1'b0;
        wait_done(1'b0, "t4b_second");
        cyc(30);
        chk("t4b_done_cnt", done_cnt_a - base, 2);
        chk("t4b_bytes_left", exp_a.size(), 0);

        // reset while pixel 3 is in flight
        push_frame_a();
        pulse_a();
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            seen = us_a && (addr_a == 3'd3) && (data_a == 8'h13);
        end
        chk("t5_reached_px3", 32'(seen), 1);
        cyc(3);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("t5_async_busy", 32'(busy_a), 0);
        chk("t5_async_addr", 32'(addr_a), 0);
        chk("t5_async_data", 32'(data_a), 0);
        chk("t5_async_start", 32'(us_a), 0);
        chk("t5_async_av", 32'(av_a), 0);
        exp_a.delete();
        exp_addr_a.delete();
        cyc(2);
        sys_rst_n = 1'b1;
        cyc(2);
        run_a("t5_fresh");

        // 4-bit pixels zero-extended on the wire
        base = done_cnt_b;
        push_frame_b();
        start_b = 1'b1; cyc(1); start_b = 1'b0;
        wait_done(1'b1, "t3");
        cyc(30);
        chk("t3_done_cnt", done_cnt_b - base, 1);
        chk("t3_bytes_left", exp_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
